// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : EX-stage branch/jump resolution against the IF prediction,
//               registered redirect/flush handshake to IF, and 2-bit bimodal
//               branch history table read by IF.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int XLEN      = 64,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_type,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int          C_BHT_N    = 1 << BHT_IDX_W;
    localparam logic [1:0]  C_WEAK_NT  = 2'b01;
    localparam logic [1:0]  C_STRONG_T = 2'b11;
    localparam logic [1:0]  C_STRONG_N = 2'b00;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_bht [0:C_BHT_N-1];
    logic [XLEN-1:0]        r_redir_pc;
    logic                   r_flush;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_accept;
    logic                   w_cond;
    logic                   w_act_taken;
    logic [XLEN-1:0]        w_pc_plus4;
    logic [XLEN-1:0]        w_act_next;
    logic [XLEN-1:0]        w_pred_next;
    logic                   w_mispredict;
    logic                   w_load_redir;
    logic                   w_bht_we;
    logic [BHT_IDX_W-1:0]   w_ex_idx;
    logic [BHT_IDX_W-1:0]   w_if_idx;
    logic [1:0]             w_bht_cur;
    logic [1:0]             w_bht_new;
    logic                   w_unused_bits;

    // ------------------------------------------------------------------------
    // Resolution datapath
    // ------------------------------------------------------------------------
    assign w_cond       = (ex_type >= 3'b001) && (ex_type <= 3'b110) && !ex_is_jump;
    assign w_act_taken  = ex_is_jump | (w_cond & ex_taken);
    assign w_pc_plus4   = ex_pc + XLEN'(4);
    assign w_act_next   = w_act_taken   ? ex_target      : w_pc_plus4;
    assign w_pred_next  = ex_pred_taken ? ex_pred_target : w_pc_plus4;
    assign w_mispredict = (w_act_next != w_pred_next);

    assign w_ex_idx  = ex_pc[BHT_IDX_W+1:2];
    assign w_if_idx  = if_pc[BHT_IDX_W+1:2];
    assign w_bht_cur = r_bht[w_ex_idx];

    always_comb begin
        w_bht_new = w_bht_cur;
        if (ex_taken) begin
            if (w_bht_cur != C_STRONG_T) w_bht_new = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != C_STRONG_N) w_bht_new = w_bht_cur - 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_redir = 1'b0;
        w_bht_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept     = ex_valid;
                w_load_redir = ex_valid & w_mispredict;
                w_bht_we     = ex_valid & w_cond;
                if (w_load_redir) w_state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redir_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Redirect registers and mispredict counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redir_pc <= '0;
            r_flush    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_flush <= w_load_redir;
            if (w_load_redir) begin
                r_redir_pc <= w_act_next;
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Write lands at the edge, so an IF read of the same index this cycle sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_BHT_N; i++) r_bht[i] <= C_WEAK_NT;
        end else if (w_bht_we) begin
            r_bht[w_ex_idx] <= w_bht_new;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_ready       = (r_state == S_IDLE);
    assign redir_valid    = (r_state == S_REDIRECT);
    assign redir_pc       = r_redir_pc;
    assign flush          = r_flush;
    assign mispredict_cnt = r_cnt;
    assign if_pred_taken  = r_bht[w_if_idx][1];

    assign w_unused_bits  = &{1'b0, if_pc[1:0], if_pc[XLEN-1:BHT_IDX_W+2], w_accept};

endmodule
`default_nettype wire
